// File: rtl/data_ram_bytelane_if.sv
// data_ram_bytelane_if: load/store bus between the CPU load/store unit and the data RAM
interface data_ram_bytelane_if #(parameter int ADDR_W = 10);
    logic              req;
    logic              sel;
    logic              we;
    logic [2:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       d;
    logic [31:0]       q;
    logic              q_valid;
    logic              misalign;
    logic              ready;
    modport master (output req, sel, we, mode, addr, d, input q, q_valid, misalign, ready);
    modport slave (input req, sel, we, mode, addr, d, output q, q_valid, misalign, ready);
endinterface

// File: rtl/data_ram_bytelane.sv
// data_ram_bytelane: 32-bit byte-lane data RAM with RISC-V sub-word loads/stores and optional clear sweep
module data_ram_bytelane #(
    parameter int ADDR_W       = 10,
    parameter bit CLEAR_ON_RST = 1
) (
    input logic                clk,
    input logic                rst,
    data_ram_bytelane_if.slave bus
);
    localparam int WORDS = 2 ** (ADDR_W - 2);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t            state;
    logic [ADDR_W-3:0] cnt;
    logic [31:0]       mem [WORDS];
    logic [ADDR_W-3:0] widx;
    logic [1:0]        lane;
    logic              acc, illegal, mis;
    logic [3:0]        be;
    logic [31:0]       wd, rw, rsh, ld;
    logic [7:0]        rb;
    logic [15:0]       rh;
    always_comb begin
        widx    = bus.addr[ADDR_W-1:2];
        lane    = bus.addr[1:0];
        acc     = bus.req && bus.sel && bus.ready && !rst;
        illegal = bus.mode == 3'b011 || bus.mode == 3'b110 || bus.mode == 3'b111;
        mis     = illegal || (bus.mode[1:0] == 2'b01 && lane[0]) || (bus.mode[1:0] == 2'b10 && lane != 2'b00);
        be      = bus.mode[1:0] == 2'b00 ? 4'b0001 << lane :
                  bus.mode[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd      = bus.mode[1:0] == 2'b00 ? {4{bus.d[7:0]}} :
                  bus.mode[1:0] == 2'b01 ? {2{bus.d[15:0]}} : bus.d;
        rw      = mem[widx];
        rsh     = rw >> {lane, 3'b000};
        rb      = rsh[7:0];
        rh      = lane[1] ? rw[31:16] : rw[15:0];
        // mode[2] selects zero extension; misaligned loads return zero
        ld      = mis ? 32'd0 :
                  bus.mode[1:0] == 2'b00 ? {{24{~bus.mode[2] & rb[7]}}, rb} :
                  bus.mode[1:0] == 2'b01 ? {{16{~bus.mode[2] & rh[15]}}, rh} : rw;
    end
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (acc && bus.we && !mis)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR_ON_RST ? CLEAR : IDLE;
            cnt          <= '0;
            bus.ready    <= !CLEAR_ON_RST;
            bus.q        <= '0;
            bus.q_valid  <= 1'b0;
            bus.misalign <= 1'b0;
        end else begin
            bus.q_valid  <= acc && !bus.we;
            bus.misalign <= acc && mis;
            if (acc && !bus.we) bus.q <= ld;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/data_ram_bytelane.md
Name: data_ram_bytelane

Overview:
- Parametrised successor to the byte-wide data RAM: 32-bit words, byte-lane writes, RISC-V sub-word load/store modes (lb/lh/lw/lbu/lhu/sb/sh/sw) and misalignment detection.
- Registered read port with a one-cycle load-valid handshake.
- Optional zero-clear sweep after reset.
- Sits behind the single-cycle/pipelined CPU's load/store unit as the data memory.

Parameters:
- ADDR_W, 10, byte-address width; storage is 2^(ADDR_W-2) words of 32 bits.
- CLEAR_ON_RST, 1, when 1 the block zeroes every word after reset before accepting requests; when 0 contents are untouched and ready rises immediately.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request.
- sel  input  1  chip select; an access is accepted only when req && sel && ready.
- we  input  1  1 = store, 0 = load.
- mode  input  3  funct3 encoding: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; all others illegal.
- addr  input  ADDR_W  byte address.
- d  input  32  store data; the low bits are used for sub-word stores.
- q  output  32  load result, extended per mode.
- q_valid  output  1  one-cycle pulse: q holds the result of the load accepted in the previous cycle.
- misalign  output  1  one-cycle pulse for a misaligned or illegal access accepted in the previous cycle.
- ready  output  1  block is able to accept requests.

Behaviour:
- Reset (rst=1 at an edge):
  - q=0, q_valid=0, misalign=0.
  - With CLEAR_ON_RST=1: FSM enters CLEAR, clear counter=0, ready=0.
  - With CLEAR_ON_RST=0: FSM enters IDLE, ready=1.
  - Reset mid-clear restarts the sweep at word 0. Reset mid-load suppresses the pending q_valid.
- FSM states: CLEAR, IDLE.
  - CLEAR writes 0 to word[counter] each cycle, counter+1.
  - After writing word 2^(ADDR_W-2)-1 the FSM goes to IDLE. ready=1 from the next cycle.
  - Clear therefore lasts exactly 2^(ADDR_W-2) cycles (256 at default).
  - req is ignored while in CLEAR: no write, no q_valid, no misalign.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- Alignment:
  - half modes require addr[0]=0.
  - word mode requires addr[1:0]=00.
  - Illegal modes always count as misaligned.
- Store (we=1), accepted at edge T:
  - sb writes byte lane addr[1:0] with d[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with d[15:0] (little-endian).
  - sw writes all four lanes with d[31:0].
  - Other lanes are unchanged.
  - Write takes effect at edge T. A store never asserts q_valid.
  - A misaligned store writes nothing; misalign=1 during cycle T+1.
- Load (we=0), accepted at edge T:
  - The word is read synchronously; q and q_valid=1 are presented during cycle T+1.
  - byte: selected byte, sign-extended (mode 000) or zero-extended (100).
  - half: selected halfword, sign-extended (001) or zero-extended (101).
  - word: full word.
  - A misaligned load gives q=0, q_valid=1, misalign=1 in cycle T+1.
- q holds its last value until the next accepted load.
- q_valid and misalign are 0 in any cycle not following an accepted access.
- Back-to-back accesses are allowed every cycle.
- A load accepted the cycle after a store to the same word returns the stored data; no bypass is needed because the write completed at the earlier edge.
- Single port: one access per cycle; no simultaneous read/write case exists.

Test Plan:
- Clear: rst high 1 cycle, CLEAR_ON_RST=1.
  - ready stays 0 for exactly 256 cycles, then goes to 1.
  - lw of addr 0x3FC then returns q=0x00000000 with q_valid.
  - A req during clear produces no q_valid.
- Word round trip: sw d=0xDEADBEEF @0x010, next cycle lw @0x010 -> q=0xDEADBEEF, q_valid=1 one cycle later.
- Byte lanes: sw 0x11223344 @0x020, then sb d=0xAA @0x022.
  - lw -> 0x11AA3344.
  - lb @0x022 -> 0xFFFFFFAA; lbu -> 0x000000AA.
  - lh @0x022 -> 0x000011AA; lhu @0x020 -> 0x00003344.
- Sign extension: sh d=0x8001 @0x030 -> lh q=0xFFFF8001, lhu q=0x00008001.
- Misalignment:
  - sw @0x041 -> misalign pulse, lw @0x040 shows original contents.
  - lh @0x043 -> q=0, q_valid=1, misalign=1.
  - mode=011 -> misalign=1.
- Reset mid-operation:
  - Assert rst the cycle after a lw -> q_valid stays 0, q=0.
  - Assert rst at clear counter 100 -> ready rises only 256 cycles after the second reset.
